// File: rtl/ucsbece152a_input_conditioner.sv
// Input conditioner for the taillight controller: it synchronizes and debounces five switch channels,
// resolves a left+right conflict into hazard, flags stable changes, and generates a PWM dimmer level.
module ucsbece152a_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DIM_PERIOD      = 8,
    parameter int DIM_DUTY        = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic left_raw_i,
    input  logic right_raw_i,
    input  logic hazard_raw_i,
    input  logic brake_raw_i,
    input  logic runlights_raw_i,
    output logic left_o,
    output logic right_o,
    output logic hazard_o,
    output logic brake_o,
    output logic runlights_o,
    output logic change_o,
    output logic dimmer_o
);
    localparam int NCH   = 5;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIM_W = $clog2(DIM_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(DIM_PERIOD - 1);

    // Channel order: 0 left, 1 right, 2 hazard, 3 brake, 4 runlights
    logic [NCH-1:0]            raw;
    logic [NCH-1:0]            sync1_q, sync2_q;
    logic [NCH-1:0]            stable_q, stable_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                      change_q, change_d;
    logic [DIM_W-1:0]          dim_q, dim_d;

    assign raw = {runlights_raw_i, brake_raw_i, hazard_raw_i, right_raw_i, left_raw_i};

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NCH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        change_d = |(stable_d ^ stable_q);
        dim_d    = (dim_q == DIM_MAX) ? '0 : dim_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            change_q <= 1'b0;
            dim_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            change_q <= change_d;
            dim_q    <= dim_d;
        end
    end

    // Both turn signals at once is treated as a hazard request
    assign hazard_o    = (stable_q[0] & stable_q[1]) | stable_q[2];
    assign left_o      = stable_q[0] & ~stable_q[1];
    assign right_o     = stable_q[1] & ~stable_q[0];
    assign brake_o     = stable_q[3];
    assign runlights_o = stable_q[4];
    assign change_o    = change_q;
    assign dimmer_o    = (32'(dim_q) < DIM_DUTY);
endmodule

// File: tb/tb_ucsbece152a_input_conditioner.sv
// Self-checking bench: directed scenarios plus random bouncing inputs, compared every cycle
// against a history-based reference model of the debounce and dimmer rules.
module tb_ucsbece152a_input_conditioner;
    localparam int D  = 4;
    localparam int P  = 8;
    localparam int DU = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] raw = '0;
    logic left_o, right_o, hazard_o, brake_o, runlights_o, change_o, dimmer_o;

    ucsbece152a_input_conditioner #(
        .DEBOUNCE_CYCLES(D), .DIM_PERIOD(P), .DIM_DUTY(DU)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .left_raw_i(raw[0]), .right_raw_i(raw[1]), .hazard_raw_i(raw[2]),
        .brake_raw_i(raw[3]), .runlights_raw_i(raw[4]),
        .left_o(left_o), .right_o(right_o), .hazard_o(hazard_o), .brake_o(brake_o),
        .runlights_o(runlights_o), .change_o(change_o), .dimmer_o(dimmer_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: raw samples seen at each edge; a channel's stable value flips once the
    // synchronized view (raw two edges back) has disagreed with it for D edges running.
    logic [4:0] hist[$];
    logic [4:0] m_st;
    logic       m_chg;
    int         m_n;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(5'b0);
        m_st  = '0;
        m_chg = 1'b0;
        m_n   = 0;
    endtask

    task automatic model_edge();
        logic [4:0] nst;
        bit alldiff;
        hist.push_back(raw);
        nst = m_st;
        for (int ch = 0; ch < 5; ch++) begin
            alldiff = 1;
            for (int j = 0; j < D; j++)
                if (hist[hist.size() - 3 - j][ch] == m_st[ch]) alldiff = 0;
            if (alldiff) nst[ch] = ~m_st[ch];
        end
        m_chg = (nst != m_st);
        m_st  = nst;
        m_n++;
        if (hist.size() > 32) void'(hist.pop_front());
    endtask

    task automatic check_all(input string tag);
        logic l, r;
        l = m_st[0];
        r = m_st[1];
        chk({tag, ".left"},   32'(left_o),      32'(l & ~r));
        chk({tag, ".right"},  32'(right_o),     32'(r & ~l));
        chk({tag, ".hazard"}, 32'(hazard_o),    32'((l & r) | m_st[2]));
        chk({tag, ".brake"},  32'(brake_o),     32'(m_st[3]));
        chk({tag, ".run"},    32'(runlights_o), 32'(m_st[4]));
        chk({tag, ".chg"},    32'(change_o),    32'(m_chg));
        chk({tag, ".dim"},    32'(dimmer_o),    32'((m_n % P) < DU));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".all0"}, 32'({left_o, right_o, hazard_o, brake_o, runlights_o, change_o}), 32'(0));
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b0000_0011;
        model_reset();
        #7;
        check_all("rst");
        chk("rst.dim1", 32'(dimmer_o), 32'(1));
        rst_n = 1'b1;

        // Dimmer free run: 1,1,0,0,0,0,0,0
        for (int e = 1; e <= 16; e++) begin
            step("dim");
            chk("dim.pat", 32'(dimmer_o), 32'(pat[e % 8]));
        end

        // Left held high: rises on the 6th edge, change for one cycle
        raw[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step("left");
            if (e == 5) chk("left.e5", 32'(left_o), 32'(0));
            if (e == 6) begin
                chk("left.e6", 32'(left_o), 32'(1));
                chk("left.chg6", 32'(change_o), 32'(1));
            end
            if (e == 7) chk("left.chg7", 32'(change_o), 32'(0));
        end
        raw[0] = 1'b0;
        for (int e = 0; e < 8; e++) step("left_off");

        // Short brake pulse is filtered
        raw[3] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            if (e == 4) raw[3] = 1'b0;
            step("brk");
            chk("brk.o", 32'(brake_o), 32'(0));
            chk("brk.chg", 32'(change_o), 32'(0));
        end

        // Left+right conflict, then release right
        raw[1:0] = 2'b11;
        for (int e = 1; e <= 6; e++) step("conf");
        chk("conf.hlr", 32'({hazard_o, left_o, right_o}), 32'(3'b100));
        raw[1] = 1'b0;
        for (int e = 1; e <= 6; e++) step("conf2");
        chk("conf2.hl", 32'({hazard_o, left_o}), 32'(2'b01));

        // Reset mid-count clears immediately; full latency after release
        raw[4] = 1'b1;
        for (int e = 0; e < 3; e++) step("run");
        async_reset("midrst");
        for (int e = 1; e <= 6; e++) begin
            step("run2");
            if (e == 5) chk("run2.e5", 32'(runlights_o), 32'(0));
            if (e == 6) chk("run2.e6", 32'(runlights_o), 32'(1));
        end
        raw = '0;
        for (int e = 0; e < 8; e++) step("clr");

        // Hazard toggling every 2 cycles never settles
        for (int e = 0; e < 40; e++) begin
            if (e % 2 == 0) raw[2] = ~raw[2];
            step("hzt");
            chk("hzt.o", 32'(hazard_o), 32'(0));
        end
        raw[2] = 1'b0;

        // Random bouncing with occasional long holds and one reset
        for (int e = 0; e < 600; e++) begin
            if ($urandom_range(0, 3) != 0) begin
                for (int ch = 0; ch < 5; ch++)
                    if ($urandom_range(0, 9) == 0) raw[ch] = ~raw[ch];
            end
            step("rnd");
            if (e == 300) async_reset("rndrst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
